branch_resolve_ctrl: RTL and testbench

//  Sequences B-type branch resolution for the RV32I core: accepts one branch op per handshake,

---
 rtl/branch_pkg.sv | 22 ++
 rtl/branch_cmp.sv | 28 ++
 rtl/branch_resolve_ctrl.sv | 153 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for RV32I branch resolution: funct3 encodings, FSM states, helpers.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    REDIR = 2'd2
  } br_state_t;

  // Targets must be 4-byte aligned: no compressed-instruction support.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch comparator: funct3 selects the condition; undefined encodings flag illegal.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: one op per handshake, done 2 edges after accept (+ redirect wait when taken).
// Redirect held until fetch accepts; optional taken/not-taken counters under BRANCH_STATS_EN.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            done,
  output logic            taken,
  output logic            illegal,
  output logic            misalign
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_ntaken
`endif
);

  br_state_t       state, state_nxt;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q;
  logic [XLEN-1:0] target;
  logic            cmp_taken, cmp_illegal;
  logic            accept;

  logic            redirect_valid_nxt;
  logic [XLEN-1:0] redirect_pc_nxt;
  logic            flush_nxt, done_nxt, taken_nxt, illegal_nxt, misalign_nxt;

  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign target    = pc_q + imm_q;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3  (f3_q),
    .rs1     (rs1_q),
    .rs2     (rs2_q),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      pc_q  <= '0;
      imm_q <= '0;
    end else if (accept) begin
      f3_q  <= funct3;
      rs1_q <= rs1;
      rs2_q <= rs2;
      pc_q  <= pc;
      imm_q <= imm;
    end
  end

  always_comb begin
    state_nxt          = state;
    redirect_valid_nxt = redirect_valid;
    redirect_pc_nxt    = redirect_pc;
    flush_nxt          = 1'b0;
    done_nxt           = 1'b0;
    taken_nxt          = taken;
    illegal_nxt        = 1'b0;
    misalign_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = CMP;
      end
      CMP: begin
        if (cmp_illegal) begin
          illegal_nxt = 1'b1;
          done_nxt    = 1'b1;
          taken_nxt   = 1'b0;
          state_nxt   = IDLE;
        end else if (cmp_taken && is_misaligned(target[1:0])) begin
          // Misaligned taken target retires as an exception, never reaches fetch.
          misalign_nxt = 1'b1;
          done_nxt     = 1'b1;
          taken_nxt    = 1'b1;
          state_nxt    = IDLE;
        end else if (cmp_taken) begin
          redirect_valid_nxt = 1'b1;
          redirect_pc_nxt    = target;
          flush_nxt          = 1'b1;
          state_nxt          = REDIR;
        end else begin
          done_nxt  = 1'b1;
          taken_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      REDIR: begin
        if (redirect_ready) begin
          redirect_valid_nxt = 1'b0;
          done_nxt           = 1'b1;
          taken_nxt          = 1'b1;
          state_nxt          = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      done           <= 1'b0;
      taken          <= 1'b0;
      illegal        <= 1'b0;
      misalign       <= 1'b0;
    end else begin
      state          <= state_nxt;
      redirect_valid <= redirect_valid_nxt;
      redirect_pc    <= redirect_pc_nxt;
      flush          <= flush_nxt;
      done           <= done_nxt;
      taken          <= taken_nxt;
      illegal        <= illegal_nxt;
      misalign       <= misalign_nxt;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken  <= '0;
      stat_ntaken <= '0;
    end else if (done_nxt && !illegal_nxt) begin
      if (taken_nxt) stat_taken  <= stat_taken + 32'd1;
      else           stat_ntaken <= stat_ntaken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Table-driven bench with a done-time scoreboard for branch_resolve_ctrl.
module tb_branch_resolve_ctrl;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, pc, imm;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush, done, taken, illegal, misalign;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken, stat_ntaken;
`endif

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .funct3         (funct3),
    .rs1            (rs1),
    .rs2            (rs2),
    .pc             (pc),
    .imm            (imm),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .done           (done),
    .taken          (taken),
    .illegal        (illegal),
    .misalign       (misalign)
`ifdef BRANCH_STATS_EN
    ,
    .stat_taken     (stat_taken),
    .stat_ntaken    (stat_ntaken)
`endif
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm;
    logic        exp_taken, exp_illegal, exp_misalign, exp_redir;
    logic [31:0] exp_pc;
    int          delay;
  } vec_t;

  typedef struct {
    logic taken, illegal, misalign;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  int   n_taken = 0;
  int   n_ntaken = 0;
  exp_t sb[$];
  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every done pulse retires the oldest outstanding op.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done=1 expected no op pending at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("sb_taken", {31'd0, taken}, {31'd0, e.taken});
        chk("sb_illegal", {31'd0, illegal}, {31'd0, e.illegal});
        chk("sb_misalign", {31'd0, misalign}, {31'd0, e.misalign});
      end
    end
  end

  // Entered and left at a negedge; the final negedge is the done cycle, so ops chain back-to-back.
  task automatic run_op(input vec_t v);
    exp_t e;
    req_valid = 1'b1;
    funct3 = v.f3; rs1 = v.rs1; rs2 = v.rs2; pc = v.pc; imm = v.imm;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    e.taken = v.exp_taken; e.illegal = v.exp_illegal; e.misalign = v.exp_misalign;
    sb.push_back(e);
    done_exp++;
    if (!v.exp_illegal) begin
      if (v.exp_taken) n_taken++;
      else             n_ntaken++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    redirect_ready = 1'b0;
    chk("cmp_done_low", {31'd0, done}, 32'd0);
    chk("cmp_flush_low", {31'd0, flush}, 32'd0);
    chk("cmp_ready_low", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("flush", {31'd0, flush}, {31'd0, v.exp_redir});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, v.exp_redir});
    chk("illegal", {31'd0, illegal}, {31'd0, v.exp_illegal});
    chk("misalign", {31'd0, misalign}, {31'd0, v.exp_misalign});
    if (v.exp_redir) begin
      chk("redirect_pc", redirect_pc, v.exp_pc);
      chk("done_at_flush", {31'd0, done}, 32'd0);
      chk("ready_at_flush", {31'd0, req_ready}, 32'd0);
      for (int i = 0; i < v.delay; i++) begin
        @(negedge clk);
        chk("hold_valid", {31'd0, redirect_valid}, 32'd1);
        chk("hold_pc", redirect_pc, v.exp_pc);
        chk("hold_ready", {31'd0, req_ready}, 32'd0);
        chk("hold_flush", {31'd0, flush}, 32'd0);
        chk("hold_done", {31'd0, done}, 32'd0);
      end
      redirect_ready = 1'b1;
      @(negedge clk);
      redirect_ready = 1'b0;
      chk("redir_done", {31'd0, done}, 32'd1);
      chk("redir_valid_clear", {31'd0, redirect_valid}, 32'd0);
    end else begin
      chk("done", {31'd0, done}, 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t hv;
    req_valid = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; pc = '0; imm = '0;
    redirect_ready = 1'b0;

    //                f3       rs1           rs2           pc            imm           tk   ill  mis  red  exp_pc        dly
    vecs[0]  = '{F3_BEQ,  32'h5,        32'h5,        32'h100,      32'h20,       1'b1,1'b0,1'b0,1'b1,32'h120,      0};
    vecs[1]  = '{F3_BLT,  32'hFFFFFFFF, 32'h1,        32'h200,      32'h40,       1'b1,1'b0,1'b0,1'b1,32'h240,      0};
    vecs[2]  = '{F3_BLTU, 32'hFFFFFFFF, 32'h1,        32'h200,      32'h40,       1'b0,1'b0,1'b0,1'b0,32'h0,        0};
    vecs[3]  = '{F3_BNE,  32'h7,        32'h7,        32'h300,      32'h8,        1'b0,1'b0,1'b0,1'b0,32'h0,        0};
    vecs[4]  = '{3'b010,  32'h1,        32'h1,        32'h300,      32'h8,        1'b0,1'b1,1'b0,1'b0,32'h0,        0};
    vecs[5]  = '{3'b011,  32'h1,        32'h2,        32'h300,      32'h8,        1'b0,1'b1,1'b0,1'b0,32'h0,        0};
    vecs[6]  = '{F3_BGEU, 32'h9,        32'h9,        32'hFFFFFFF0, 32'h14,       1'b1,1'b0,1'b0,1'b1,32'h00000004, 0};
    vecs[7]  = '{F3_BGEU, 32'h9,        32'h9,        32'hFFFFFFF0, 32'h12,       1'b1,1'b0,1'b1,1'b0,32'h0,        0};
    vecs[8]  = '{F3_BGE,  32'h80000000, 32'h7FFFFFFF, 32'h400,      32'h8,        1'b0,1'b0,1'b0,1'b0,32'h0,        0};
    vecs[9]  = '{F3_BGE,  32'h3,        32'hFFFFFFFD, 32'h1000,     32'hFFFFFFF0, 1'b1,1'b0,1'b0,1'b1,32'h00000FF0, 0};
    vecs[10] = '{F3_BGEU, 32'h3,        32'hFFFFFFFD, 32'h1000,     32'hFFFFFFF0, 1'b0,1'b0,1'b0,1'b0,32'h0,        0};
    vecs[11] = '{F3_BLTU, 32'h0,        32'h1,        32'h40,       32'h100,      1'b1,1'b0,1'b0,1'b1,32'h140,      0};
    vecs[12] = '{F3_BEQ,  32'h1,        32'h2,        32'h40,       32'h100,      1'b0,1'b0,1'b0,1'b0,32'h0,        0};
    vecs[13] = '{F3_BNE,  32'h1,        32'h2,        32'h80,       32'hFFFFFFFE, 1'b1,1'b0,1'b1,1'b0,32'h0,        0};
    vecs[14] = '{F3_BGE,  32'h5,        32'h5,        32'h10,       32'h10,       1'b1,1'b0,1'b0,1'b1,32'h20,       0};
    vecs[15] = '{F3_BNE,  32'hA,        32'hB,        32'h500,      32'h4,        1'b1,1'b0,1'b0,1'b1,32'h504,      5};

    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i]);

`ifdef BRANCH_STATS_EN
    chk("stat_taken", stat_taken, n_taken);
    chk("stat_ntaken", stat_ntaken, n_ntaken);
`endif

    // Reset while a redirect is pending: everything drops immediately.
    hv = '{F3_BNE, 32'h1, 32'h2, 32'h600, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h604, 0};
    req_valid = 1'b1;
    funct3 = hv.f3; rs1 = hv.rs1; rs2 = hv.rs2; pc = hv.pc; imm = hv.imm;
    chk("rr_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    redirect_ready = 1'b0;
    @(negedge clk);
    chk("rr_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("rr_redirect_pc", redirect_pc, hv.exp_pc);
    @(negedge clk);
    chk("rr_still_waiting", {31'd0, redirect_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_valid_cleared", {31'd0, redirect_valid}, 32'd0);
    chk("rr_pc_cleared", redirect_pc, 32'd0);
    chk("rr_req_ready_low", {31'd0, req_ready}, 32'd0);
    chk("rr_done_low", {31'd0, done}, 32'd0);
    chk("rr_taken_low", {31'd0, taken}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk("rr_stat_taken", stat_taken, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rr_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("rr_no_redirect", {31'd0, redirect_valid}, 32'd0);

    chk("done_count", done_seen, done_exp);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
